// File: rtl/bcd_scan_decoder_if.sv
// Load and display bundle of bcd_scan_decoder.
// The master drives the load/clear side; the slave (decoder) drives the display side.
interface bcd_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load_valid;
   logic                    load_ready;
   logic [4*NUM_DIGITS-1:0] load_data;
   logic                    err_clr;
   logic [9:0]              dec_out;
   logic [NUM_DIGITS-1:0]   digit_sel;
   logic                    frame_last;
   logic                    invalid_digit;
   logic                    err_sticky;

   modport master (
      output load_valid, load_data, err_clr,
      input  load_ready, dec_out, digit_sel, frame_last, invalid_digit, err_sticky
   );

   modport slave (
      input  load_valid, load_data, err_clr,
      output load_ready, dec_out, digit_sel, frame_last, invalid_digit, err_sticky
   );
endinterface

// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed BCD-to-one-hot decimal decoder with a double-buffered digit word.
// Each digit is shown for DWELL cycles; non-BCD digits are flagged and latched in err_sticky.
module bcd_scan_decoder #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL        = 4,
   parameter bit INVALID_MODE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   bcd_scan_decoder_if.slave bus
);
   localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int                DW_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int                WORD_W   = 4 * NUM_DIGITS;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DW_W-1:0]   DW_LAST  = DW_W'(DWELL - 1);

   typedef enum logic {IDLE, SCAN} state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] active_q, active_d;
   logic [WORD_W-1:0] pending_q, pending_d;
   logic              pending_full_q, pending_full_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic              err_q, err_d;

   logic       scanning;
   logic       dwell_last;
   logic       frame_last;
   logic       load_fire;
   logic [3:0] cur_digit;
   logic       cur_invalid;

   assign scanning    = (state_q == SCAN);
   assign dwell_last  = (dwell_q == DW_LAST);
   assign frame_last  = scanning && dwell_last && (index_q == IDX_LAST);
   assign load_fire   = bus.load_valid && !pending_full_q;
   assign cur_digit   = active_q[4*int'(index_q) +: 4];
   assign cur_invalid = (cur_digit > 4'd9);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         active_q       <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         index_q        <= '0;
         dwell_q        <= '0;
         err_q          <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         state_q        <= state_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         index_q        <= index_d;
         dwell_q        <= dwell_d;
         err_q          <= err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every target gets a hold default first so no path through this block infers a latch.
      state_d        = state_q;
      active_d       = active_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      index_d        = index_q;
      dwell_d        = dwell_q;
      err_d          = err_q;

      case (state_q)
         IDLE: begin
            if (load_fire) begin
               state_d  = SCAN;
               active_d = bus.load_data;
               index_d  = '0;
               dwell_d  = '0;
            end
         end
         SCAN: begin
            if (dwell_last) begin
               dwell_d = '0;
               index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
            // The active word only changes on a frame boundary; a load there bypasses pending.
            if (frame_last) begin
               if (pending_full_q) begin
                  active_d       = pending_q;
                  pending_full_d = 1'b0;
               end else if (load_fire) begin
                  active_d = bus.load_data;
               end
            end else if (load_fire) begin
               pending_d      = bus.load_data;
               pending_full_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (scanning && cur_invalid) begin
         err_d = 1'b1;
      end else if (bus.err_clr) begin
         err_d = 1'b0;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      bus.dec_out       = '0;
      bus.digit_sel     = '0;
      bus.frame_last    = 1'b0;
      bus.invalid_digit = 1'b0;
      if (scanning) begin
         bus.digit_sel     = NUM_DIGITS'(1) << index_q;
         bus.frame_last    = frame_last;
         bus.invalid_digit = cur_invalid;
         if (cur_invalid) begin
            bus.dec_out = INVALID_MODE ? 10'h000 : 10'h3FF;
         end else begin
            bus.dec_out = 10'd1 << cur_digit;
         end
      end
   end

   assign bus.load_ready = !pending_full_q;
   assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Self-checking bench for bcd_scan_decoder: a frame-position model feeds a scoreboard queue,
// and per-scenario tasks add directed checks against constant expectations.
module tb_bcd_scan_decoder;
  localparam int N = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_scan_decoder_if #(.NUM_DIGITS(N)) b0 ();
  bcd_scan_decoder_if #(.NUM_DIGITS(N)) b1 ();

  assign b1.load_valid = b0.load_valid;
  assign b1.load_data  = b0.load_data;
  assign b1.err_clr    = b0.err_clr;

  bcd_scan_decoder #(.NUM_DIGITS(N), .DWELL(D), .INVALID_MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  bcd_scan_decoder #(.NUM_DIGITS(N), .DWELL(D), .INVALID_MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  typedef struct packed {
    logic [9:0] dec0;
    logic [9:0] dec1;
    logic [3:0] sel;
    logic       fl;
    logic       inv;
    logic       ready;
    logic       err;
  } exp_t;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: position within the frame rather than digit/dwell counters.
  bit          m_scan  = 1'b0;
  logic [15:0] m_word  = '0;
  logic [15:0] m_pend  = '0;
  bit          m_pfull = 1'b0;
  bit          m_err   = 1'b0;
  int          m_pos   = 0;
  exp_t        exp_q[$];

  function automatic exp_t model_out();
    exp_t       e;
    int         dig;
    logic [3:0] v;
    e       = '0;
    e.ready = !m_pfull;
    e.err   = m_err;
    if (m_scan) begin
      dig   = m_pos / D;
      v     = 4'(m_word >> (4 * dig));
      e.sel = 4'(1 << dig);
      e.fl  = (m_pos == N * D - 1);
      if (v > 4'd9) begin
        e.inv  = 1'b1;
        e.dec0 = 10'h3FF;
        e.dec1 = 10'h000;
      end else begin
        e.dec0 = 10'(1 << v);
        e.dec1 = e.dec0;
      end
    end
    return e;
  endfunction

  task automatic reset_model();
    m_scan  = 1'b0;
    m_word  = '0;
    m_pend  = '0;
    m_pfull = 1'b0;
    m_err   = 1'b0;
    m_pos   = 0;
    exp_q.delete();
  endtask

  always @(posedge clk) begin
    logic       fire;
    logic [3:0] v;
    if (!rst) begin
      v    = 4'(m_word >> (4 * (m_pos / D)));
      fire = b0.load_valid && !m_pfull;
      if (m_scan && v > 4'd9) m_err = 1'b1;
      else if (b0.err_clr) m_err = 1'b0;
      if (!m_scan) begin
        if (fire) begin
          m_scan = 1'b1;
          m_word = b0.load_data;
          m_pos  = 0;
        end
      end else if (m_pos == N * D - 1) begin
        m_pos = 0;
        if (m_pfull) begin
          m_word  = m_pend;
          m_pfull = 1'b0;
        end else if (fire) begin
          m_word = b0.load_data;
        end
      end else begin
        m_pos = m_pos + 1;
        if (fire) begin
          m_pend  = b0.load_data;
          m_pfull = 1'b1;
        end
      end
      exp_q.push_back(model_out());
    end
  end

  // Scoreboard consumer: compare every registered-state decode on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (b0.dec_out !== e.dec0) $display("FAIL sb_dec_out t=%0t got %h want %h", $time, b0.dec_out, e.dec0);
      else n_pass++;
      n_total++;
      if (b1.dec_out !== e.dec1) $display("FAIL sb_dec_out_mode1 t=%0t got %h want %h", $time, b1.dec_out, e.dec1);
      else n_pass++;
      n_total++;
      if (b0.digit_sel !== e.sel) $display("FAIL sb_digit_sel t=%0t got %b want %b", $time, b0.digit_sel, e.sel);
      else n_pass++;
      n_total++;
      if ({b0.frame_last, b0.invalid_digit} !== {e.fl, e.inv})
        $display("FAIL sb_flags t=%0t got fl=%b inv=%b want fl=%b inv=%b", $time, b0.frame_last, b0.invalid_digit, e.fl, e.inv);
      else n_pass++;
      n_total++;
      if ({b0.load_ready, b0.err_sticky} !== {e.ready, e.err})
        $display("FAIL sb_ready_err t=%0t got rdy=%b err=%b want rdy=%b err=%b", $time, b0.load_ready, b0.err_sticky, e.ready, e.err);
      else n_pass++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    reset_model();
    repeat (2) @(negedge clk);
    n_total++;
    if ({b0.dec_out, b0.digit_sel, b0.frame_last, b0.invalid_digit, b0.load_ready, b0.err_sticky} !==
        {10'h000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_outputs got dec=%h sel=%b fl=%b inv=%b rdy=%b err=%b want 000 0000 0 0 1 0",
               b0.dec_out, b0.digit_sel, b0.frame_last, b0.invalid_digit, b0.load_ready, b0.err_sticky);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_pattern();
    logic [9:0] dec_tbl[4] = '{10'h001, 10'h080, 10'h008, 10'h200};
    @(negedge clk);
    b0.load_valid = 1'b1;
    b0.load_data  = 16'h9370;
    @(negedge clk);
    b0.load_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      int dg;
      dg = ((c - 1) / D) % N;
      if (c > 1) @(negedge clk);
      n_total++;
      if (b0.digit_sel !== 4'(1 << dg) || b0.dec_out !== dec_tbl[dg])
        $display("FAIL pattern_c%0d got sel=%b dec=%h want sel=%b dec=%h", c, b0.digit_sel, b0.dec_out, 4'(1 << dg), dec_tbl[dg]);
      else n_pass++;
      n_total++;
      if (b0.frame_last !== 1'(c % 8 == 0))
        $display("FAIL pattern_fl_c%0d got %b want %b", c, b0.frame_last, 1'(c % 8 == 0));
      else n_pass++;
    end
  endtask

  task automatic test_pending();
    repeat (3) @(negedge clk);
    b0.load_valid = 1'b1;
    b0.load_data  = 16'h1234;
    @(negedge clk);
    b0.load_valid = 1'b0;
    n_total++;
    if (b0.load_ready !== 1'b0) $display("FAIL pending_ready_low got %b want 0", b0.load_ready);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if ({b0.frame_last, b0.dec_out, b0.load_ready} !== {1'b1, 10'h200, 1'b0})
      $display("FAIL pending_old_frame got fl=%b dec=%h rdy=%b want 1 200 0", b0.frame_last, b0.dec_out, b0.load_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({b0.dec_out, b0.load_ready} !== {10'h010, 1'b1})
      $display("FAIL pending_swap got dec=%h rdy=%b want 010 1", b0.dec_out, b0.load_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (b0.dec_out !== 10'h008) $display("FAIL pending_d1 got %h want 008", b0.dec_out);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (b0.dec_out !== 10'h004) $display("FAIL pending_d2 got %h want 004", b0.dec_out);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if (b0.dec_out !== 10'h002) $display("FAIL pending_d3 got %h want 002", b0.dec_out);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] dec_tbl[4] = '{10'h040, 10'h100, 10'h020, 10'h001};
    n_total++;
    if ({b0.frame_last, b0.load_ready} !== 2'b11)
      $display("FAIL bypass_setup got fl=%b rdy=%b want 1 1", b0.frame_last, b0.load_ready);
    else n_pass++;
    b0.load_valid = 1'b1;
    b0.load_data  = 16'h0586;
    @(negedge clk);
    b0.load_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      n_total++;
      if ({b0.dec_out, b0.load_ready} !== {dec_tbl[(c - 1) / D], 1'b1})
        $display("FAIL bypass_c%0d got dec=%h rdy=%b want %h 1", c, b0.dec_out, b0.load_ready, dec_tbl[(c - 1) / D]);
      else n_pass++;
    end
  endtask

  task automatic test_invalid();
    b0.load_valid = 1'b1;
    b0.load_data  = 16'h00A0;
    @(negedge clk);
    b0.load_valid = 1'b0;
    n_total++;
    if ({b0.dec_out, b0.err_sticky} !== {10'h001, 1'b0})
      $display("FAIL invalid_c1 got dec=%h err=%b want 001 0", b0.dec_out, b0.err_sticky);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if ({b0.dec_out, b1.dec_out, b0.invalid_digit, b0.err_sticky} !== {10'h3FF, 10'h000, 1'b1, 1'b0})
      $display("FAIL invalid_c3 got dec0=%h dec1=%h inv=%b err=%b want 3ff 000 1 0",
               b0.dec_out, b1.dec_out, b0.invalid_digit, b0.err_sticky);
    else n_pass++;
    b0.err_clr = 1'b1;
    @(negedge clk);
    n_total++;
    if ({b0.invalid_digit, b0.err_sticky} !== 2'b11)
      $display("FAIL invalid_err_set got inv=%b err=%b want 1 1", b0.invalid_digit, b0.err_sticky);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({b0.invalid_digit, b0.err_sticky, b0.dec_out} !== {1'b0, 1'b1, 10'h001})
      $display("FAIL invalid_set_wins got inv=%b err=%b dec=%h want 0 1 001", b0.invalid_digit, b0.err_sticky, b0.dec_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (b0.err_sticky !== 1'b0) $display("FAIL invalid_err_clr got %b want 0", b0.err_sticky);
    else n_pass++;
    b0.err_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    b0.load_valid = 1'b1;
    b0.load_data  = 16'h5555;
    @(negedge clk);
    b0.load_valid = 1'b0;
    n_total++;
    if ({b0.load_ready, b0.frame_last} !== 2'b00)
      $display("FAIL areset_pending got rdy=%b fl=%b want 0 0", b0.load_ready, b0.frame_last);
    else n_pass++;
    #2;
    rst = 1'b1;
    reset_model();
    #1;
    n_total++;
    if ({b0.dec_out, b1.dec_out, b0.digit_sel, b0.frame_last, b0.invalid_digit, b0.load_ready, b0.err_sticky} !==
        {10'h000, 10'h000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL areset_outputs got dec=%h sel=%b fl=%b inv=%b rdy=%b err=%b want 000 0000 0 0 1 0",
               b0.dec_out, b0.digit_sel, b0.frame_last, b0.invalid_digit, b0.load_ready, b0.err_sticky);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if ({b0.dec_out, b0.digit_sel, b0.load_ready} !== {10'h000, 4'h0, 1'b1})
      $display("FAIL areset_idle got dec=%h sel=%b rdy=%b want 000 0000 1", b0.dec_out, b0.digit_sel, b0.load_ready);
    else n_pass++;
    b0.load_valid = 1'b1;
    b0.load_data  = 16'h4321;
    @(negedge clk);
    b0.load_valid = 1'b0;
    n_total++;
    if ({b0.dec_out, b0.digit_sel} !== {10'h002, 4'b0001})
      $display("FAIL areset_reload got dec=%h sel=%b want 002 0001", b0.dec_out, b0.digit_sel);
    else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    b0.load_valid = 1'b0;
    b0.load_data  = '0;
    b0.err_clr    = 1'b0;
    test_reset();
    test_pattern();
    test_pending();
    test_back_to_back();
    test_invalid();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bcd_scan_decoder.md
Name: bcd_scan_decoder

Overview:
- Time-multiplexed, multi-digit BCD-to-decimal decoder for scanned one-hot (1-of-10) digit displays or indicator banks.
- Holds a double-buffered NUM_DIGITS-digit BCD word and steps through the digits one at a time, DWELL cycles each.
- For each digit it drives a 10-bit one-hot decimal code and a one-hot digit select.
- Flags non-BCD digits (values above 9) on the current digit and in a sticky error bit.

Parameters:
- NUM_DIGITS, 4: number of BCD digits scanned; must be 1 or more.
- DWELL, 4: clock cycles each digit is held; must be 1 or more.
- INVALID_MODE, 0: output for a digit above 9. 0 drives all ones (10'h3FF). 1 blanks the output (10'h000).

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous reset, active-high.
- load_valid  in  1: load_data is offered.
- load_ready  out  1: block can accept a load this cycle.
- load_data  in  4*NUM_DIGITS: packed BCD word. Digit k occupies bits [4k+3:4k]. Digit 0 is scanned first.
- err_clr  in  1: clears err_sticky.
- dec_out  out  10: one-hot decimal code of the current digit. Bit n is set for value n.
- digit_sel  out  NUM_DIGITS: one-hot select of the current digit.
- frame_last  out  1: current cycle is the last cycle of a frame.
- invalid_digit  out  1: current digit is above 9.
- err_sticky  out  1: an invalid digit has been displayed since the last clear.

Behaviour:
- State registers:
  - state: IDLE or SCAN.
  - active word.
  - pending word plus pending_full flag.
  - digit index, 0..NUM_DIGITS-1.
  - dwell count, 0..DWELL-1.
  - err_sticky.
- Counter widths are $clog2 of the range, with a minimum of 1 bit.
- dec_out, digit_sel, frame_last, invalid_digit and load_ready are combinational decodes of registered state only. No input-to-output combinational paths.
- Reset (asynchronous, immediate):
  - state = IDLE; active = 0; pending dropped (pending_full = 0); index = 0; dwell = 0; err_sticky = 0.
  - Outputs: dec_out = 0, digit_sel = 0, frame_last = 0, invalid_digit = 0, load_ready = 1.
  - Reset mid-scan aborts the frame and discards both buffers.
- A load is accepted when load_valid and load_ready are both high on a rising edge.
- load_ready = !pending_full.
- IDLE:
  - All outputs are 0 except load_ready.
  - On an accepted load: active <= load_data, index = 0, dwell = 0, state becomes SCAN.
  - The first digit appears in the cycle after acceptance (latency 1).
- SCAN:
  - digit_sel = one-hot of index.
  - Current digit d = active[index].
  - If d <= 9: dec_out = 1 << d and invalid_digit = 0.
  - If d > 9: dec_out follows INVALID_MODE and invalid_digit = 1.
- Scan stepping, each cycle:
  - dwell increments.
  - When dwell reaches DWELL-1, it wraps to 0 and index increments.
  - When index reaches NUM_DIGITS-1 with dwell = DWELL-1, index wraps to 0. frame_last is high in exactly that cycle.
  - Frame length is NUM_DIGITS*DWELL cycles. Scanning repeats the active word indefinitely; the block never returns to IDLE except through reset.
- Loads during SCAN:
  - An accepted load writes pending, and pending_full is set, so load_ready falls in the next cycle.
  - At the frame_last edge with pending_full set: active <= pending and pending_full clears.
  - At the frame_last edge with pending empty and a load accepted in the same cycle: the data bypasses pending straight into active. pending_full stays 0.
  - The active word never changes mid-frame.
- Error flag:
  - err_sticky sets at the edge following any SCAN cycle with invalid_digit = 1.
  - err_clr clears it. If set and clear coincide, set wins.
- Edge case: with NUM_DIGITS = 1 and DWELL = 1, frame_last is constantly high in SCAN, and a swap can occur every cycle.

Test Plan:
- Reset with NUM_DIGITS=4, DWELL=2 -> dec_out=0, digit_sel=0, load_ready=1, err_sticky=0.
- Load 16'h9370 in IDLE -> starting the next cycle, each line holds 2 cycles:
  - digit_sel 0001, dec_out 10'b00_0000_0001
  - digit_sel 0010, dec_out 10'b00_1000_0000
  - digit_sel 0100, dec_out 10'b00_0000_1000
  - digit_sel 1000, dec_out 10'b10_0000_0000
  - frame_last high on cycle 8; the pattern then repeats.
- Load 16'h1234 at cycle 3 of a frame -> load_ready goes 0 the next cycle. The old word finishes its frame. The next frame shows digits 4,3,2,1, and load_ready returns to 1 after the swap.
- Load offered exactly in the frame_last cycle with pending empty -> the next frame shows the new word and load_ready stays 1 throughout.
- Digit value 4'hA:
  - INVALID_MODE=0 -> dec_out = 10'h3FF, invalid_digit = 1, err_sticky = 1 from the next cycle.
  - err_clr held while the invalid digit is still displayed -> err_sticky stays 1 (set wins).
  - err_clr after the invalid digit ends -> err_sticky = 0.
  - INVALID_MODE=1 -> dec_out = 0.
- rst asserted asynchronously mid-frame with pending_full set -> all outputs go 0 before the next edge and load_ready = 1. After release, state is IDLE and the pending word is not displayed.
